// File: rtl/power_pkg.sv
// Shared definitions for the power-meter controller and the display/game logic around it.
package power_pkg;

  localparam int unsigned POWER_W       = 8;
  localparam int unsigned DEF_MAX_POWER = 100;
  localparam int unsigned DEF_STEP      = 1;

  typedef enum logic [2:0] {
    IDLE,
    CHARGE_UP,
    CHARGE_DOWN,
    FIRE,
    COOLDOWN
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider. It emits a one-cycle tick every DIV clocks.
// A synchronous clear holds the count at zero.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (clear || tick) count <= '0;
    else               count <= count + CW'(1);
  end

endmodule

// File: rtl/power_charge_ctrl.sv
// Power-meter controller: ping-pong ramp while the button is held, fire pulse on release,
// then hold the latched power through a cooldown.
module power_charge_ctrl
  import power_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 2_500_000,
  parameter int unsigned MAX_POWER   = DEF_MAX_POWER,
  parameter int unsigned STEP        = DEF_STEP,
  parameter int unsigned COOL_CYCLES = 50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn,
  input  logic         enable,
  output logic [7:0]   power,
  output logic         charging,
  output logic         fire,
  output logic [7:0]   fire_power
);

  localparam int unsigned CCW = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;

  state_t               state, state_d;
  logic [POWER_W-1:0]   power_d, fire_power_d;
  logic                 fire_d, charging_d;
  logic [CCW-1:0]       cool_cnt, cool_d;
  logic                 btn_q, press, tick, in_charge;
  logic [POWER_W:0]     sum;

  assign press     = btn & ~btn_q;
  assign in_charge = (state == CHARGE_UP) || (state == CHARGE_DOWN);
  assign sum       = {1'b0, power} + (POWER_W + 1)'(STEP);

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .clear (rst | ~in_charge),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    // btn_q follows btn even in reset so a button held across reset release is not an edge
    btn_q <= btn;
    if (rst) begin
      state      <= IDLE;
      power      <= '0;
      fire_power <= '0;
      fire       <= 1'b0;
      charging   <= 1'b0;
      cool_cnt   <= '0;
    end else begin
      state      <= state_d;
      power      <= power_d;
      fire_power <= fire_power_d;
      fire       <= fire_d;
      charging   <= charging_d;
      cool_cnt   <= cool_d;
    end
  end

  always_comb begin
    state_d      = state;
    power_d      = power;
    fire_power_d = fire_power;
    fire_d       = 1'b0;
    cool_d       = cool_cnt;
    case (state)
      IDLE: begin
        power_d = '0;
        if (press && enable) state_d = CHARGE_UP;
      end
      CHARGE_UP, CHARGE_DOWN: begin
        // abort beats release, release beats a same-cycle tick
        if (!enable) begin
          state_d = IDLE;
          power_d = '0;
        end else if (!btn) begin
          state_d      = FIRE;
          fire_d       = 1'b1;
          fire_power_d = power;
        end else if (tick) begin
          if (state == CHARGE_UP) begin
            if (sum >= (POWER_W + 1)'(MAX_POWER)) begin
              power_d = POWER_W'(MAX_POWER);
              state_d = CHARGE_DOWN;
            end else begin
              power_d = sum[POWER_W-1:0];
            end
          end else begin
            if (power <= POWER_W'(STEP)) begin
              power_d = '0;
              state_d = CHARGE_UP;
            end else begin
              power_d = power - POWER_W'(STEP);
            end
          end
        end
      end
      FIRE: begin
        state_d = COOLDOWN;
        cool_d  = '0;
      end
      COOLDOWN: begin
        if (cool_cnt == CCW'(COOL_CYCLES - 1)) begin
          state_d = IDLE;
          power_d = '0;
        end else begin
          cool_d = cool_cnt + CCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        power_d = '0;
      end
    endcase
    charging_d = (state_d == CHARGE_UP) || (state_d == CHARGE_DOWN);
  end

endmodule

// File: tb/tb_power_charge_ctrl.sv
// Bench for power_charge_ctrl: reference model indexed by elapsed charge time, directed scenarios
// with literal expectations, then a randomized soak.
module tb_power_charge_ctrl;

  localparam int TDIV = 4;
  localparam int MAXP = 10;
  localparam int STP  = 3;
  localparam int COOL = 5;

  logic       clk = 1'b0;
  logic       rst, btn, enable;
  logic [7:0] power, fire_power;
  logic       charging, fire;

  power_charge_ctrl #(
    .TICK_DIV(TDIV), .MAX_POWER(MAXP), .STEP(STP), .COOL_CYCLES(COOL)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .enable(enable),
    .power(power), .charging(charging), .fire(fire), .fire_power(fire_power)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Power after k ticks of a charge that starts at 0: triangle wave clipped at MAXP.
  function automatic int ramp(input int k);
    int p = 0;
    bit up = 1;
    for (int i = 0; i < k; i++) begin
      if (up) begin
        if (p + STP >= MAXP) begin p = MAXP; up = 0; end
        else p = p + STP;
      end else begin
        if (p <= STP) begin p = 0; up = 1; end
        else p = p - STP;
      end
    end
    return p;
  endfunction

  // phase: 0 idle, 1 charging, 2 fire cycle, 3 cooldown
  int m_phase = 0, m_cyc = 0, m_cool = 0, m_power = 0, m_fp = 0;
  bit m_fire = 0, m_prev_btn = 0;

  always @(posedge clk) begin
    m_fire = 0;
    if (rst) begin
      m_phase = 0; m_power = 0; m_fp = 0; m_cyc = 0; m_cool = 0;
    end else begin
      case (m_phase)
        0: begin
          m_power = 0;
          if (btn && !m_prev_btn && enable) begin m_phase = 1; m_cyc = 0; end
        end
        1: begin
          if (!enable) begin m_phase = 0; m_power = 0; end
          else if (!btn) begin m_phase = 2; m_fire = 1; m_fp = m_power; end
          else begin m_cyc++; m_power = ramp(m_cyc / TDIV); end
        end
        2: begin m_phase = 3; m_cool = 0; end
        default: begin
          m_cool++;
          if (m_cool == COOL) begin m_phase = 0; m_power = 0; end
        end
      endcase
    end
    m_prev_btn = btn;
  end

  bit prev_fire = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_power",      int'(power),      m_power);
      chk("model_charging",   int'(charging),   int'(m_phase == 1));
      chk("model_fire",       int'(fire),       int'(m_fire));
      chk("model_fire_power", int'(fire_power), m_fp);
      chk("power_le_max",     int'(power <= 8'(MAXP)), 1);
      chk("no_double_fire",   int'(fire && prev_fire), 0);
      prev_fire = fire;
    end
  end

  int exp_ramp [10] = '{0, 3, 6, 9, 10, 7, 4, 1, 0, 3};

  initial begin
    rst = 1; btn = 0; enable = 1;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("reset_power", int'(power), 0);
    chk("reset_fire_power", int'(fire_power), 0);
    chk("reset_fire", int'(fire), 0);
    chk("reset_charging", int'(charging), 0);
    rst = 0;
    @(negedge clk);

    // 1: hold and follow the ping-pong ramp
    btn = 1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("ramp_%0d", k), int'(power), exp_ramp[k]);
      chk("ramp_charging", int'(charging), 1);
      repeat (TDIV) @(negedge clk);
    end

    // 2: release at power 6
    chk("pre_release_power", int'(power), 6);
    btn = 0;
    @(negedge clk);
    chk("fire_pulse", int'(fire), 1);
    chk("fire_power_6", int'(fire_power), 6);
    @(negedge clk);
    chk("fire_single_cycle", int'(fire), 0);
    chk("cool_hold_start", int'(power), 6);
    repeat (4) @(negedge clk);
    chk("cool_hold_end", int'(power), 6);
    @(negedge clk);
    chk("back_to_idle_power", int'(power), 0);
    chk("back_to_idle_charging", int'(charging), 0);

    // 3: release coincides with the 6 -> 9 tick
    btn = 1;
    repeat (12) @(negedge clk);
    chk("tick_release_power", int'(power), 6);
    btn = 0;
    @(negedge clk);
    chk("tick_release_fire", int'(fire), 1);
    chk("tick_release_fire_power", int'(fire_power), 6);
    repeat (6) @(negedge clk);

    // 4: drop enable at power 9
    btn = 1;
    repeat (14) @(negedge clk);
    chk("abort_pre_power", int'(power), 9);
    enable = 0;
    @(negedge clk);
    chk("abort_power", int'(power), 0);
    chk("abort_charging", int'(charging), 0);
    chk("abort_no_fire", int'(fire), 0);
    chk("abort_fire_power_kept", int'(fire_power), 6);
    enable = 1; btn = 0;
    @(negedge clk);

    // 5: button held through reset, press during cooldown, fresh press
    rst = 1; btn = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("held_through_reset", int'(charging), 0);
    end
    btn = 0;
    @(negedge clk);
    btn = 1;
    repeat (2) @(negedge clk);
    btn = 0;
    @(negedge clk);
    chk("fire_zero_power", int'(fire), 1);
    @(negedge clk);
    btn = 1;
    repeat (8) @(negedge clk);
    chk("cooldown_press_ignored", int'(charging), 0);
    btn = 0;
    @(negedge clk);
    btn = 1;
    @(negedge clk);
    chk("fresh_press_charges", int'(charging), 1);

    // 6: reset lands on the release cycle
    repeat (5) @(negedge clk);
    btn = 0; rst = 1;
    @(negedge clk);
    chk("rst_kills_fire", int'(fire), 0);
    chk("rst_power", int'(power), 0);
    chk("rst_fire_power", int'(fire_power), 0);
    chk("rst_charging", int'(charging), 0);
    rst = 0;

    // randomized soak
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) btn = ~btn;
      enable = ($urandom_range(0, 49) != 0);
      rst    = ($urandom_range(0, 299) == 0);
    end
    rst = 0;
    @(negedge clk);
    chk_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
